// File: rtl/data_access_unit.sv
// data_access_unit: M-stage memory sequencer.
// Splits scalar and vector loads/stores into WORD_W beats on a req/ack port
// and raises BusyDA while an access is in flight so the pipeline stalls.
// Optional feature macro: DA_TIMEOUT_EN adds a per-beat watchdog that aborts
// a stuck access and sets the sticky ErrDA flag.
module data_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int VEC_W       = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              VecM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [WORD_W-1:0] WriteDataM,
  input  logic [VEC_W-1:0]  WriteDataVM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic [VEC_W-1:0]  ReadDataVM,
  output logic              BusyDA,
  output logic              ErrDA,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int BEATS      = VEC_W / WORD_W;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int WORD_BYTES = WORD_W / 8;
  localparam int VEC_BYTES  = VEC_W / 8;

  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] VEC_MASK  = ADDR_W'(VEC_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Elaboration-time parameter sanity checks.
  if (BEATS < 2 || BEATS * WORD_W != VEC_W) begin : g_bad_beats
    $error("data_access_unit: VEC_W must be an integer multiple (>=2) of WORD_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("data_access_unit: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [VEC_W-1:0]    rdata_q, rdata_d;
  logic                fast_done;
  logic                start;
  logic                is_last;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   beat_addr;
  logic [WORD_W-1:0]   beat_wdata;

`ifdef DA_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  // A new access begins only from IDLE; reset suppresses any new request.
  assign start   = (MemReadM | MemWriteM) & (state_q == IDLE) & ~rst;
  assign is_last = ~VecM | (beat_q == LAST_BEAT);

  // Beat address: align down to the access size, then step one word per beat.
  assign base_addr  = AddrM & ~(VecM ? VEC_MASK : WORD_MASK);
  assign beat_addr  = base_addr + (ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES));
  assign beat_wdata = VecM ? WriteDataVM[beat_q*WORD_W +: WORD_W] : WriteDataM;

  // Port outputs are zero whenever no beat is being requested.
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = mem_req ? beat_addr  : '0;
  assign mem_wdata = mem_req ? beat_wdata : '0;

  // Scalar same-cycle completion forwards the memory word straight through.
  assign ReadDataM  = fast_done ? mem_rdata : rdata_q[WORD_W-1:0];
  assign ReadDataVM = rdata_q;

`ifdef DA_TIMEOUT_EN
  assign ErrDA = err_q;
`else
  assign ErrDA = 1'b0;
`endif

  // Next-state, beat sequencing, read-data capture and request/stall outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    beat_d    = beat_q;
    rdata_d   = rdata_q;
    mem_req   = 1'b0;
    BusyDA    = 1'b0;
    fast_done = 1'b0;
`ifdef DA_TIMEOUT_EN
    wait_d    = wait_q;
    err_d     = err_q;
`endif

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mem_req = 1'b1;
            beat_d  = '0;
            // Clear so any beat never received reads back as zero.
            rdata_d = '0;
            if (mem_ack && !MemWriteM) begin
              rdata_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
            end
            if (mem_ack && !VecM) begin
              fast_done = 1'b1;
            end else begin
              BusyDA  = 1'b1;
              state_d = ACCESS;
              if (mem_ack) begin
                beat_d = beat_q + 1'b1;
              end
            end
          end
        end

        ACCESS: begin
          mem_req = 1'b1;
          BusyDA  = 1'b1;
          if (mem_ack) begin
            if (!MemWriteM) begin
              rdata_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
            end
            if (is_last) begin
              state_d = DONE;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end

        DONE: begin
          state_d = IDLE;
          beat_d  = '0;
        end

        default: begin
          state_d = IDLE;
          beat_d  = '0;
        end
      endcase

`ifdef DA_TIMEOUT_EN
      // Watchdog: count unanswered request cycles of the current beat.
      if (mem_req) begin
        if (mem_ack) begin
          wait_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
          beat_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`endif
    end
  end

  // State, beat counter and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the read-data register is reset too, so loads never expose stale data after reset.
      state_q <= IDLE;
      beat_q  <= '0;
      rdata_q <= '0;
`ifdef DA_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
`ifdef DA_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_access_unit.sv
// Testbench for data_access_unit (default build, BEATS = 4).
// A behavioural memory acks each beat after a programmable delay; expected
// beats are queued when an access is launched and popped as beats are accepted.
module tb_data_access_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemReadM, MemWriteM, VecM;
  logic [31:0]  AddrM, WriteDataM;
  logic [127:0] WriteDataVM;
  logic [31:0]  ReadDataM;
  logic [127:0] ReadDataVM;
  logic         BusyDA, ErrDA;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic         rd;
    logic         wr;
    logic         vec;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] wdatav;
    int           delay;
    int           exp_busy;
  } access_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t   exp_q[$];
  beat_t   mon_e;
  access_t tbl[8];
  access_t rst_acc;
  int      n_cmp     = 0;
  int      n_bad     = 0;
  int      ack_delay = 0;
  int      wait_cnt  = 0;

  data_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .VecM       (VecM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .WriteDataVM(WriteDataVM),
    .ReadDataM  (ReadDataM),
    .ReadDataVM (ReadDataVM),
    .BusyDA     (BusyDA),
    .ErrDA      (ErrDA),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of the byte address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] exp_vec(input logic [31:0] base);
    return {mem_model(base + 32'd12), mem_model(base + 32'd8),
            mem_model(base + 32'd4),  mem_model(base)};
  endfunction

  // Responder: ack once the request has waited ack_delay cycles (0 = same cycle).
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_req ? mem_model(mem_addr) : 32'h0;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got addr %0h expected no beat", mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_we",   128'(mem_we),   128'(mon_e.we));
        check("beat_addr", 128'(mem_addr), 128'(mon_e.addr));
        if (mon_e.we) check("beat_wdata", 128'(mem_wdata), 128'(mon_e.wdata));
      end
    end
  end

  function automatic logic [31:0] base_of(input access_t a);
    return a.vec ? (a.addr & 32'hFFFF_FFF0) : (a.addr & 32'hFFFF_FFFC);
  endfunction

  task automatic push_beats(input access_t a);
    logic [31:0] base;
    beat_t       b;
    int          n;
    base = base_of(a);
    n    = a.vec ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      b.we    = a.wr;
      b.addr  = base + 32'(4 * k);
      b.wdata = a.vec ? a.wdatav[32*k +: 32] : a.wdata;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive(input access_t a);
    ack_delay   = a.delay;
    MemReadM    = a.rd;
    MemWriteM   = a.wr;
    VecM        = a.vec;
    AddrM       = a.addr;
    WriteDataM  = a.wdata;
    WriteDataVM = a.wdatav;
  endtask

  task automatic idle_inputs();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    VecM      = 1'b0;
  endtask

  // Launch one access (called just after a rising edge) and follow it to completion.
  task automatic run_access(input access_t a, input string tag);
    logic [31:0] base;
    int          busy;
    int          cyc;
    bit          done;
    bit          is_load;
    base    = base_of(a);
    is_load = a.rd && !a.wr;
    push_beats(a);
    drive(a);
    busy = 0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (BusyDA === 1'b1) begin
        busy++;
        check({tag, "_req_held"}, 128'(mem_req), 128'(1'b1));
      end else begin
        done = 1;
        if (busy == 0) begin
          check({tag, "_fast_req"}, 128'(mem_req), 128'(1'b1));
          if (is_load) check({tag, "_fast_rdata"}, 128'(ReadDataM), 128'(mem_model(base)));
        end else begin
          check({tag, "_done_req"}, 128'(mem_req), 128'(1'b0));
          if (is_load && a.vec)  check({tag, "_done_rdatav"}, ReadDataVM, exp_vec(base));
          if (is_load && !a.vec) check({tag, "_done_rdata"}, 128'(ReadDataM), 128'(mem_model(base)));
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy for %0d cycles expected completion", tag, cyc);
    end
    check({tag, "_busy_cycles"}, 128'(busy), 128'(a.exp_busy));
    check({tag, "_err"}, 128'(ErrDA), 128'(1'b0));
    @(posedge clk);
    #1;
    check({tag, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // rd, wr, vec, addr, wdata, wdatav, ack delay, expected BusyDA cycles
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 128'h0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0, 128'h0, 0, 4};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,
               128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 2, 12};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0036, 32'hCAFE_F00D, 128'h0, 1, 2};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'h0,
               128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 4};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0047, 32'h0, 128'h0, 3, 4};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h1234_5678, 128'h0, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_1004, 32'h0, 128'h0, 1, 8};

    rst         = 1'b1;
    idle_inputs();
    AddrM       = 32'h0;
    WriteDataM  = 32'h0;
    WriteDataVM = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy",   128'(BusyDA),    128'(1'b0));
    check("rst_req",    128'(mem_req),   128'(1'b0));
    check("rst_we",     128'(mem_we),    128'(1'b0));
    check("rst_addr",   128'(mem_addr),  128'(32'h0));
    check("rst_err",    128'(ErrDA),     128'(1'b0));
    check("rst_rdata",  128'(ReadDataM), 128'(32'h0));
    check("rst_rdatav", ReadDataVM,      128'h0);
    @(posedge clk);
    #1;

    // Table-driven accesses.
    for (int i = 0; i < 8; i++) begin
      run_access(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a vector load, after beat 1 has been accepted.
    rst_acc = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 128'h0, 0, 4};
    push_beats(rst_acc);
    drive(rst_acc);
    @(negedge clk);
    check("mid_busy0", 128'(BusyDA), 128'(1'b1));
    @(negedge clk);
    check("mid_busy1", 128'(BusyDA), 128'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_req", 128'(mem_req), 128'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req",    128'(mem_req), 128'(1'b0));
    check("post_rst_busy",   128'(BusyDA),  128'(1'b0));
    check("post_rst_rdatav", ReadDataVM,    128'h0);
    @(posedge clk);
    #1;
    // A fresh access must restart from beat 0 at the aligned base.
    run_access(rst_acc, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
